program_loader: RTL

Boot-time sequencer that owns the instruction-memory write port and the branch-predictor history table while the RV32I core is held in reset. It accepts 32-bit instruction words over a valid/ready stream and writes each word into byte-addressed instruction RAM, most-significant byte first. It then initializes every BHT entry to weakly-not-taken and releases the core's reset. It sits between the host/boot source and the core's fetch stage and is the only writer of imem and BHT during a load session.

---
 rtl/program_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot-time loader: streams instruction words into byte-wide imem (MSB first),
// seeds every BHT entry, then releases the core from reset.
module program_loader #(
  parameter int          IMEM_BYTES  = 1024,
  parameter int          BHT_ENTRIES = 16,
  parameter logic [1:0]  BHT_INIT    = 2'b01,
  localparam int         ADDR_W      = $clog2(IMEM_BYTES),
  localparam int         IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [15:0]       word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              bht_we,
  output logic [IDX_W-1:0]  bht_idx,
  output logic [1:0]        bht_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, BHT, DONE, RUN} state_t;

  state_t      state;
  logic [15:0] w;
  logic [15:0] count;
  logic [1:0]  k;
  logic [31:0] word;
  logic [17:0] need;
  logic        overflow;
  logic        last_word;

  assign need      = {word_count, 2'b00};
  assign overflow  = need > 18'(IMEM_BYTES);
  assign last_word = (w + 16'd1) == count;
  assign bht_wdata = BHT_INIT;

  // Outputs are registered alongside the state so they always describe the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      core_reset <= 1'b1;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      bht_we     <= 1'b0;
      bht_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      w          <= '0;
      count      <= '0;
      k          <= '0;
      word       <= '0;
    end else begin
      in_ready <= 1'b0;
      imem_we  <= 1'b0;
      bht_we   <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (load_start) begin
            if (overflow) begin
              err        <= 1'b1;
              state      <= IDLE;
              core_reset <= 1'b1;
            end else begin
              err        <= 1'b0;
              w          <= '0;
              count      <= word_count;
              busy       <= 1'b1;
              core_reset <= 1'b1;
              if (word_count != 16'd0) begin
                state    <= ACCEPT;
                in_ready <= 1'b1;
              end else begin
                state   <= BHT;
                bht_we  <= 1'b1;
                bht_idx <= '0;
              end
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            // The remaining bytes are shifted up so byte k+1 is always at the top.
            word       <= {in_data[23:0], 8'h00};
            k          <= 2'd0;
            state      <= WRITE;
            imem_we    <= 1'b1;
            imem_addr  <= {w[ADDR_W-3:0], 2'b00};
            imem_wdata <= in_data[31:24];
          end else begin
            in_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (k == 2'd3) begin
            w <= w + 16'd1;
            if (last_word) begin
              state   <= BHT;
              bht_we  <= 1'b1;
              bht_idx <= '0;
            end else begin
              state    <= ACCEPT;
              in_ready <= 1'b1;
            end
          end else begin
            k          <= k + 2'd1;
            imem_we    <= 1'b1;
            imem_addr  <= imem_addr + ADDR_W'(1);
            imem_wdata <= word[31:24];
            word       <= {word[23:0], 8'h00};
          end
        end
        BHT: begin
          if (bht_idx == IDX_W'(BHT_ENTRIES - 1)) begin
            state      <= DONE;
            done       <= 1'b1;
            core_reset <= 1'b0;
            busy       <= 1'b0;
          end else begin
            bht_we  <= 1'b1;
            bht_idx <= bht_idx + IDX_W'(1);
          end
        end
        DONE: begin
          state <= RUN;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
